riscv_mem_reqbuf: RTL and testbench

- Consumer side of the MMU-to-memory request interface.
- Accepts the translated request stream (req/adr/size/lock/we plus write data) and queues it in a small FIFO.
- Issues queued requests to the BIU with a strobe/acknowledge handshake and tracks outstanding accesses.
- Returns completion (ack/q/err) to the CPU pipeline and back-pressures the MMU stage through stall_o.

---
 rtl/biu_constants_pkg.sv | 14 +
 rtl/riscv_mem_reqbuf.sv | 147 ++++++++++++++
 tb/tb_riscv_mem_reqbuf.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_constants_pkg.sv
// Shared BIU definitions.
//   biu_size_t : transfer size encoding carried on the MMU and BIU request buses.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE    = 3'd0,
        HWORD   = 3'd1,
        WORD    = 3'd2,
        DWORD   = 3'd3,
        QWORD   = 3'd4,
        OCTWORD = 3'd5
    } biu_size_t;

endpackage

// File: rtl/riscv_mem_reqbuf.sv
// riscv_mem_reqbuf
//   Consumer side of the MMU-to-memory request path. Translated requests are
//   queued in a small FIFO, issued to the BIU with a strobe/ack handshake, and
//   their completions are returned to the CPU as a registered ack/q/err pulse.
//
// Ports
//   rst_ni, clk_i       asynchronous active-low reset, rising-edge clock
//   flush_i             drop queued requests, suppress in-flight completions
//   req_i/adr_i/size_i/lock_i/we_i/d_i   request from the MMU stage
//   stall_o             FIFO full, upstream holds its request
//   ack_o/q_o/err_o     completion to the CPU (q_o/err_o hold when ack_o=0)
//   biu_stb_o/biu_stb_ack_i              request handshake to the BIU
//   biu_adr_o/size_o/lock_o/we_o/d_o     head entry payload
//   biu_d_ack_i/biu_q_i/biu_err_i        access completion from the BIU
module riscv_mem_reqbuf
    import biu_constants_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PLEN  = XLEN,
    parameter int DEPTH = 2
) (
    input  logic            rst_ni,
    input  logic            clk_i,
    input  logic            flush_i,

    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            lock_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    output logic            stall_o,

    output logic            ack_o,
    output logic [XLEN-1:0] q_o,
    output logic            err_o,

    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    output logic [PLEN-1:0] biu_adr_o,
    output biu_size_t       biu_size_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_d_ack_i,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_err_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [PLEN-1:0] adr;
        biu_size_t       size;
        logic            lock;
        logic            we;
        logic [XLEN-1:0] d;
    } entry_t;

    entry_t          mem_q [DEPTH];

    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]   out_cnt_q,  out_cnt_d;
    logic [CW-1:0]   disc_cnt_q, disc_cnt_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic            ack_q,      ack_d;
    logic            err_q,      err_d;
    logic [XLEN-1:0] q_q,        q_d;

    logic            push;
    logic            pop;
    logic            cmpl;
    entry_t          head;

    assign stall_o   = (fifo_cnt_q == CW'(DEPTH));
    assign biu_stb_o = (fifo_cnt_q != '0) && (out_cnt_q < CW'(DEPTH));

    assign push = req_i && !stall_o && !flush_i;
    assign pop  = biu_stb_o && biu_stb_ack_i;
    // A completion with nothing outstanding is a protocol violation (e.g. a
    // stale response after reset); ignoring it keeps the counters consistent.
    assign cmpl = biu_d_ack_i && (out_cnt_q != '0);

    assign head       = mem_q[rd_ptr_q];
    assign biu_adr_o  = head.adr;
    assign biu_size_o = head.size;
    assign biu_lock_o = head.lock;
    assign biu_we_o   = head.we;
    assign biu_d_o    = head.d;

    assign ack_o = ack_q;
    assign q_o   = q_q;
    assign err_o = err_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        // Flush empties the queue by collapsing the read pointer onto the
        // write pointer; any push this cycle is already blocked.
        rd_ptr_d   = flush_i ? wr_ptr_q : rd_ptr_q + PW'(pop);
        fifo_cnt_d = flush_i ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
        // A pop in the flush cycle was accepted by the BIU, so it still counts.
        out_cnt_d  = out_cnt_q + CW'(pop) - CW'(cmpl);

        disc_cnt_d = disc_cnt_q;
        if (flush_i) begin
            disc_cnt_d = out_cnt_d;
        end else if (cmpl && disc_cnt_q != '0) begin
            disc_cnt_d = disc_cnt_q - 1'b1;
        end

        ack_d = cmpl && (disc_cnt_q == '0) && !flush_i;
        q_d   = ack_d ? biu_q_i   : q_q;
        err_d = ack_d ? biu_err_i : err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            q_q        <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            q_q        <= q_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{adr: adr_i, size: size_i, lock: lock_i, we: we_i, d: d_i};
        end
    end

endmodule

// File: tb/tb_riscv_mem_reqbuf.sv
module tb_riscv_mem_reqbuf;
    import biu_constants_pkg::*;

    localparam int XLEN  = 32;
    localparam int PLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            req_i;
    logic [PLEN-1:0] adr_i;
    biu_size_t       size_i;
    logic            lock_i;
    logic            we_i;
    logic [XLEN-1:0] d_i;
    logic            stall_o;
    logic            ack_o;
    logic [XLEN-1:0] q_o;
    logic            err_o;
    logic            biu_stb_o;
    logic            biu_stb_ack_i;
    logic [PLEN-1:0] biu_adr_o;
    biu_size_t       biu_size_o;
    logic            biu_lock_o;
    logic            biu_we_o;
    logic [XLEN-1:0] biu_d_o;
    logic            biu_d_ack_i;
    logic [XLEN-1:0] biu_q_i;
    logic            biu_err_i;

    int total = 0;
    int bad   = 0;
    int tb_out = 0;   // accesses the bench has seen accepted but not completed

    riscv_mem_reqbuf #(.XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH)) dut (
        .rst_ni        (rst_ni),
        .clk_i         (clk_i),
        .flush_i       (flush_i),
        .req_i         (req_i),
        .adr_i         (adr_i),
        .size_i        (size_i),
        .lock_i        (lock_i),
        .we_i          (we_i),
        .d_i           (d_i),
        .stall_o       (stall_o),
        .ack_o         (ack_o),
        .q_o           (q_o),
        .err_o         (err_o),
        .biu_stb_o     (biu_stb_o),
        .biu_stb_ack_i (biu_stb_ack_i),
        .biu_adr_o     (biu_adr_o),
        .biu_size_o    (biu_size_o),
        .biu_lock_o    (biu_lock_o),
        .biu_we_o      (biu_we_o),
        .biu_d_o       (biu_d_o),
        .biu_d_ack_i   (biu_d_ack_i),
        .biu_q_i       (biu_q_i),
        .biu_err_i     (biu_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Bus-side monitor: tracks outstanding accesses, flags completions with
    // nothing outstanding, and prints one line per completion to the CPU.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tb_out = 0;
        end else begin
            if (biu_d_ack_i && tb_out == 0) begin
                total++;
                bad++;
                $display("FAIL protocol: d_ack with outstanding=%0d required >0", tb_out);
            end
            tb_out = tb_out + ((biu_stb_o && biu_stb_ack_i) ? 1 : 0) - (biu_d_ack_i ? 1 : 0);
            if (ack_o) $display("txn t=%0t ack q=%h err=%b", $time, q_o, err_o);
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        flush_i = 0; req_i = 0; adr_i = '0; size_i = WORD; lock_i = 0; we_i = 0;
        d_i = '0; biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_q_i = '0; biu_err_i = 0;
    endtask

    // Issue one read and return its data; leaves the bench just after the
    // edge that registered the completion.
    task automatic do_read(input logic [PLEN-1:0] a, input logic [XLEN-1:0] q, input logic e);
        req_i = 1; adr_i = a; we_i = 0;
        tick();
        req_i = 0; biu_stb_ack_i = 1;
        tick();
        biu_stb_ack_i = 0; biu_d_ack_i = 1; biu_q_i = q; biu_err_i = e;
        tick();
        biu_d_ack_i = 0; biu_err_i = 0;
        #1;
    endtask

    // Empty the queue and retire all outstanding accesses (bounded).
    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            biu_stb_ack_i = 1;
            biu_d_ack_i   = (tb_out != 0);
            #1;
            if (!biu_stb_o && tb_out == 0) break;
            tick();
        end
        biu_stb_ack_i = 0; biu_d_ack_i = 0;
        tick();
        total++;
        if (biu_stb_o !== 1'b0 || tb_out != 0) begin
            bad++;
            $display("FAIL drain_timeout: stb=%b out=%0d required 0/0", biu_stb_o, tb_out);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        #1;
        total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        total++; if (ack_o !== 1'b0)     begin bad++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        total++; if (q_o !== 32'h0)      begin bad++; $display("FAIL rst_q: got %h want 0", q_o); end
        total++; if (err_o !== 1'b0)     begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", biu_stb_o); end
        tick(); tick();
        rst_ni = 1;
        tick();
    endtask

    task automatic test_read();
        req_i = 1; adr_i = 32'h100; we_i = 0; size_i = WORD;
        #1;
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL read_stb_empty: got %b want 0", biu_stb_o); end
        tick();
        req_i = 0;
        #1;
        total++; if (biu_stb_o !== 1'b1)      begin bad++; $display("FAIL read_stb: got %b want 1", biu_stb_o); end
        total++; if (biu_adr_o !== 32'h100)   begin bad++; $display("FAIL read_adr: got %h want 100", biu_adr_o); end
        total++; if (biu_we_o !== 1'b0)       begin bad++; $display("FAIL read_we: got %b want 0", biu_we_o); end
        total++; if (biu_size_o !== WORD)     begin bad++; $display("FAIL read_size: got %0d want %0d", biu_size_o, WORD); end
        biu_stb_ack_i = 1;
        tick();
        biu_stb_ack_i = 0;
        #1;
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL read_stb_popped: got %b want 0", biu_stb_o); end
        biu_d_ack_i = 1; biu_q_i = 32'hDEADBEEF;
        #1;
        total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL read_ack_early: got %b want 0", ack_o); end
        tick();
        biu_d_ack_i = 0; biu_q_i = '0;
        #1;
        total++; if (ack_o !== 1'b1)          begin bad++; $display("FAIL read_ack: got %b want 1", ack_o); end
        total++; if (q_o !== 32'hDEADBEEF)    begin bad++; $display("FAIL read_q: got %h want deadbeef", q_o); end
        total++; if (err_o !== 1'b0)          begin bad++; $display("FAIL read_err: got %b want 0", err_o); end
        tick();
        #1;
        total++; if (ack_o !== 1'b0)          begin bad++; $display("FAIL read_ack_pulse: got %b want 0", ack_o); end
        total++; if (q_o !== 32'hDEADBEEF)    begin bad++; $display("FAIL read_q_hold: got %h want deadbeef", q_o); end
    endtask

    task automatic test_fill();
        req_i = 1; adr_i = 32'h200; we_i = 1; d_i = 32'hAAAA0000; lock_i = 1;
        tick();
        adr_i = 32'h204; d_i = 32'hAAAA0004; lock_i = 0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fill_stall1: got %b want 0", stall_o); end
        tick();
        adr_i = 32'h208; d_i = 32'hAAAA0008;
        #1;
        total++; if (stall_o !== 1'b1)          begin bad++; $display("FAIL fill_stall2: got %b want 1", stall_o); end
        total++; if (biu_adr_o !== 32'h200)     begin bad++; $display("FAIL fill_head: got %h want 200", biu_adr_o); end
        total++; if (biu_d_o !== 32'hAAAA0000)  begin bad++; $display("FAIL fill_d: got %h want aaaa0000", biu_d_o); end
        total++; if (biu_lock_o !== 1'b1)       begin bad++; $display("FAIL fill_lock: got %b want 1", biu_lock_o); end
        tick();
        #1;
        total++; if (stall_o !== 1'b1 || biu_adr_o !== 32'h200) begin
            bad++; $display("FAIL fill_hold: stall=%b adr=%h want 1/200", stall_o, biu_adr_o); end
        biu_stb_ack_i = 1;
        tick();
        biu_stb_ack_i = 0;
        #1;
        total++; if (stall_o !== 1'b0)      begin bad++; $display("FAIL fill_stall_drop: got %b want 0", stall_o); end
        total++; if (biu_adr_o !== 32'h204) begin bad++; $display("FAIL fill_head2: got %h want 204", biu_adr_o); end
        total++; if (biu_lock_o !== 1'b0)   begin bad++; $display("FAIL fill_lock2: got %b want 0", biu_lock_o); end
        tick();
        req_i = 0; we_i = 0;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL fill_stall3: got %b want 1", stall_o); end
        drain();
    endtask

    task automatic test_outstanding();
        biu_stb_ack_i = 1;
        req_i = 1; adr_i = 32'h400;
        tick();
        adr_i = 32'h404;
        tick();
        adr_i = 32'h408;
        tick();
        req_i = 0;
        #1;
        total++; if (biu_stb_o !== 1'b0)    begin bad++; $display("FAIL out_limit: got %b want 0", biu_stb_o); end
        total++; if (biu_adr_o !== 32'h408) begin bad++; $display("FAIL out_head: got %h want 408", biu_adr_o); end
        tick();
        biu_d_ack_i = 1; biu_q_i = 32'h11;
        #1;
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL out_limit2: got %b want 0", biu_stb_o); end
        tick();
        biu_d_ack_i = 0;
        #1;
        total++; if (biu_stb_o !== 1'b1) begin bad++; $display("FAIL out_reassert: got %b want 1", biu_stb_o); end
        total++; if (ack_o !== 1'b1 || q_o !== 32'h11) begin
            bad++; $display("FAIL out_ack1: ack=%b q=%h want 1/11", ack_o, q_o); end
        tick();
        biu_stb_ack_i = 0; biu_d_ack_i = 1; biu_q_i = 32'h22;
        #1;
        total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL out_ack_gap: got %b want 0", ack_o); end
        tick();
        biu_q_i = 32'h33;
        #1;
        total++; if (ack_o !== 1'b1 || q_o !== 32'h22) begin
            bad++; $display("FAIL out_ack2: ack=%b q=%h want 1/22", ack_o, q_o); end
        tick();
        biu_d_ack_i = 0;
        #1;
        total++; if (ack_o !== 1'b1 || q_o !== 32'h33) begin
            bad++; $display("FAIL out_ack3: ack=%b q=%h want 1/33", ack_o, q_o); end
        tick();
    endtask

    task automatic test_flush();
        req_i = 1; adr_i = 32'h500;
        tick();
        adr_i = 32'h504; biu_stb_ack_i = 1;
        tick();
        req_i = 0; biu_stb_ack_i = 0; flush_i = 1;
        tick();
        flush_i = 0;
        #1;
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", biu_stb_o); end
        total++; if (ack_o !== 1'b0)     begin bad++; $display("FAIL flush_ack_after: got %b want 0", ack_o); end
        biu_d_ack_i = 1; biu_q_i = 32'hBAD;
        tick();
        biu_d_ack_i = 0;
        #1;
        total++; if (ack_o !== 1'b0)     begin bad++; $display("FAIL flush_suppress: got %b want 0", ack_o); end
        total++; if (q_o === 32'hBAD)    begin bad++; $display("FAIL flush_q: got %h want not bad", q_o); end
        tick();
        do_read(32'h600, 32'h600D, 1'b0);
        total++; if (ack_o !== 1'b1 || q_o !== 32'h600D) begin
            bad++; $display("FAIL flush_next: ack=%b q=%h want 1/600d", ack_o, q_o); end
        tick();
    endtask

    task automatic test_error();
        do_read(32'h700, 32'h55, 1'b1);
        total++; if (ack_o !== 1'b1 || err_o !== 1'b1) begin
            bad++; $display("FAIL err_set: ack=%b err=%b want 1/1", ack_o, err_o); end
        tick();
        #1;
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_hold: got %b want 1", err_o); end
        do_read(32'h704, 32'h66, 1'b0);
        total++; if (ack_o !== 1'b1 || err_o !== 1'b0 || q_o !== 32'h66) begin
            bad++; $display("FAIL err_clear: ack=%b err=%b q=%h want 1/0/66", ack_o, err_o, q_o); end
        tick();
    endtask

    task automatic test_reset_midop();
        req_i = 1; adr_i = 32'h800;
        tick();
        adr_i = 32'h804; biu_stb_ack_i = 1;
        tick();
        adr_i = 32'h808; biu_stb_ack_i = 0;
        tick();
        req_i = 0;
        #1;
        total++; if (stall_o !== 1'b1 || biu_stb_o !== 1'b1) begin
            bad++; $display("FAIL mid_pre: stall=%b stb=%b want 1/1", stall_o, biu_stb_o); end
        rst_ni = 0;
        #1;
        total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL mid_stall: got %b want 0", stall_o); end
        total++; if (biu_stb_o !== 1'b0) begin bad++; $display("FAIL mid_stb: got %b want 0", biu_stb_o); end
        total++; if (q_o !== 32'h0 || ack_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL mid_outs: ack=%b q=%h err=%b want 0/0/0", ack_o, q_o, err_o); end
        tick(); tick();
        rst_ni = 1;
        tick();
        do_read(32'h900, 32'h12345678, 1'b0);
        total++; if (ack_o !== 1'b1 || q_o !== 32'h12345678) begin
            bad++; $display("FAIL mid_after: ack=%b q=%h want 1/12345678", ack_o, q_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_fill();
        test_outstanding();
        test_flush();
        test_error();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
